// File: rtl/tick_sched_pkg.sv
// Shared constants for the tick scheduler: the channel modes and the channel FSM states.
// There are no ports. Other files pull these in with import tick_sched_pkg::*.
package tick_sched_pkg;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/tick_channel.sv
// One scheduler channel. It holds the period/mode registers and runs a down-counter off base_tick.
// Ports: clk, rst, base_tick_i, start_i, stop_i, cfg_we_i/cfg_period_i/cfg_mode_i, tick_o, busy_o.
module tick_channel
  import tick_sched_pkg::*;
#(
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          base_tick_i,
  input  logic          start_i,
  input  logic          stop_i,
  input  logic          cfg_we_i,
  input  logic [CW-1:0] cfg_period_i,
  input  logic          cfg_mode_i,
  output logic          tick_o,
  output logic          busy_o
);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] period_q;
  logic          mode_q;
  logic          tick_q;

  // Start and reload read period_q before any same-edge cfg write lands.
  // This means a write takes effect only from the next reload onward.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      mode_q   <= MODE_PERIODIC;
      tick_q   <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      if (cfg_we_i) begin
        period_q <= cfg_period_i;
        mode_q   <= cfg_mode_i;
      end
      if (stop_i) begin
        state_q <= ST_IDLE;
      end else if (start_i && (period_q != '0)) begin
        cnt_q   <= period_q;
        state_q <= ST_RUN;
      end else if ((state_q == ST_RUN) && base_tick_i) begin
        if (cnt_q != CW'(1)) begin
          cnt_q <= cnt_q - CW'(1);
        end else begin
          tick_q <= 1'b1;
          if ((mode_q == MODE_ONESHOT) || (period_q == '0)) begin
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= period_q;
          end
        end
      end
    end
  end

  assign tick_o = tick_q;
  assign busy_o = (state_q == ST_RUN);

endmodule

// File: rtl/tick_scheduler.sv
// Shared free-running prescaler that drives NCH independent tick channels.
// Ports: clk, rst, cfg_we/cfg_ch/cfg_period/cfg_mode, start, stop, tick, busy, base_tick.
module tick_scheduler
  import tick_sched_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned BASE_HZ = 1_000,
  parameter int unsigned NCH     = 4,
  parameter int unsigned CW      = 16,
  localparam int unsigned CHW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cfg_we,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [CW-1:0]  cfg_period,
  input  logic           cfg_mode,
  input  logic [NCH-1:0] start,
  input  logic [NCH-1:0] stop,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] busy,
  output logic           base_tick
);

  localparam int unsigned PRESCALE = CLK_HZ / BASE_HZ;
  localparam int unsigned PW       = $clog2(PRESCALE);

  logic [PW-1:0] pcnt_q, pcnt_d;
  logic          btick_q, btick_d;
  logic          pwrap;

  assign pwrap = (pcnt_q == PW'(PRESCALE - 1));

  always_comb begin
    pcnt_d  = pwrap ? '0 : pcnt_q + PW'(1);
    btick_d = pwrap;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q  <= '0;
      btick_q <= 1'b0;
    end else begin
      pcnt_q  <= pcnt_d;
      btick_q <= btick_d;
    end
  end

  assign base_tick = btick_q;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic we;
    // If the index is out of range, it matches no channel and the write is dropped.
    assign we = cfg_we && (32'(cfg_ch) == i);

    tick_channel #(.CW(CW)) u_ch (
      .clk         (clk),
      .rst         (rst),
      .base_tick_i (btick_q),
      .start_i     (start[i]),
      .stop_i      (stop[i]),
      .cfg_we_i    (we),
      .cfg_period_i(cfg_period),
      .cfg_mode_i  (cfg_mode),
      .tick_o      (tick[i]),
      .busy_o      (busy[i])
    );
  end

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler with PRESCALE=10, NCH=4, CW=8.
// Expected tick pulses are queued by the stimulus process and checked by a separate monitor.
module tb_tick_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_ch = '0;
  logic [7:0] cfg_period = '0;
  logic       cfg_mode = 1'b0;
  logic [3:0] start = '0;
  logic [3:0] stop = '0;
  logic [3:0] tick;
  logic [3:0] busy;
  logic       base_tick;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int         cyc;
    logic [3:0] tick;
  } exp_t;

  exp_t q[$];

  tick_scheduler #(
    .CLK_HZ (10),
    .BASE_HZ(1),
    .NCH    (4),
    .CW     (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_period(cfg_period),
    .cfg_mode  (cfg_mode),
    .start     (start),
    .stop      (stop),
    .tick      (tick),
    .busy      (busy),
    .base_tick (base_tick)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  task automatic push(input int c, input logic [3:0] t);
    exp_t e;
    int   i;
    e.cyc  = c;
    e.tick = t;
    i = 0;
    while (i < q.size() && q[i].cyc <= c) i++;
    q.insert(i, e);
  endtask

  // Monitor: a tick is due on a queued cycle. Any other tick is spurious.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc < cyc) begin
      chk("tick_missed_cycle", cyc, q[0].cyc);
      void'(q.pop_front());
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      chk("tick", int'(tick), int'(q[0].tick));
      void'(q.pop_front());
    end else if (tick != 4'b0) begin
      chk("spurious_tick", int'(tick), 0);
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic wait_base(output int c);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!base_tick && n < 20);
    chk("base_wait", int'(base_tick), 1);
    c = cyc;
  endtask

  task automatic cfg(input int ch, input int per, input logic md);
    cfg_we     = 1'b1;
    cfg_ch     = 2'(ch);
    cfg_period = 8'(per);
    cfg_mode   = md;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic pulse(input logic [3:0] st, input logic [3:0] sp);
    start = st;
    stop  = sp;
    @(negedge clk);
    start = '0;
    stop  = '0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int c;
    repeat (3) @(negedge clk);
    chk("rst_tick", int'(tick), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_base", int'(base_tick), 0);
    rst = 1'b0;
    r = cyc;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      chk("base_tick_phase", int'(base_tick), int'(k == 10 || k == 20));
    end
    chk("idle_busy", int'(busy), 0);

    // Channel 0 runs periodic with period 3. It is then stopped and started in the same cycle.
    cfg(0, 3, 1'b0);
    wait_base(c);
    push(c + 31, 4'b0001);
    push(c + 61, 4'b0001);
    push(c + 91, 4'b0001);
    pulse(4'b0001, 4'b0000);
    wait_cyc(c + 31);
    chk("busy0_t1", int'(busy[0]), 1);
    wait_cyc(c + 61);
    chk("busy0_t2", int'(busy[0]), 1);
    wait_cyc(c + 91);
    chk("busy0_t3", int'(busy[0]), 1);
    wait_cyc(c + 120);
    pulse(4'b0001, 4'b0001);
    chk("stop_wins_busy0", int'(busy[0]), 0);
    wait_cyc(c + 135);
    chk("stopped_busy0", int'(busy[0]), 0);

    // Retrigger on the expiry edge, then a mid-interval period change from 3 to 5.
    wait_base(c);
    push(c + 31, 4'b0001);
    push(c + 91, 4'b0001);
    push(c + 121, 4'b0001);
    push(c + 171, 4'b0001);
    push(c + 221, 4'b0001);
    pulse(4'b0001, 4'b0000);
    wait_cyc(c + 60);
    pulse(4'b0001, 4'b0000);
    wait_cyc(c + 105);
    cfg(0, 5, 1'b0);
    wait_cyc(c + 225);
    pulse(4'b0000, 4'b0001);
    chk("stop_busy0", int'(busy[0]), 0);

    // Channel 1 runs one-shot with period 2.
    cfg(1, 2, 1'b1);
    wait_base(c);
    push(c + 21, 4'b0010);
    pulse(4'b0010, 4'b0000);
    wait_cyc(c + 20);
    chk("oneshot_busy_before", int'(busy[1]), 1);
    wait_cyc(c + 21);
    chk("oneshot_busy_at_tick", int'(busy[1]), 0);
    wait_cyc(c + 60);
    chk("oneshot_busy_after", int'(busy[1]), 0);

    // Channel 2 gets a cfg write and a start in the same cycle, so the old period is used first.
    cfg(2, 2, 1'b0);
    wait_base(c);
    cfg_we     = 1'b1;
    cfg_ch     = 2'd2;
    cfg_period = 8'd4;
    cfg_mode   = 1'b0;
    start      = 4'b0100;
    push(c + 21, 4'b0100);
    push(c + 61, 4'b0100);
    @(negedge clk);
    cfg_we = 1'b0;
    start  = '0;
    wait_cyc(c + 65);
    pulse(4'b0000, 4'b0100);
    chk("stop_busy2", int'(busy[2]), 0);

    // Channel 3 has period 0, so its start is ignored.
    pulse(4'b1000, 4'b0000);
    chk("zero_period_busy3", int'(busy[3]), 0);
    repeat (3) @(negedge clk);
    chk("zero_period_busy3_later", int'(busy[3]), 0);

    // Channels 0 and 1 tick together. A reset on the next expiry edge drops that tick.
    cfg(0, 2, 1'b0);
    wait_base(c);
    push(c + 21, 4'b0011);
    push(c + 41, 4'b0001);
    pulse(4'b0011, 4'b0000);
    wait_cyc(c + 41);
    chk("busy_after_joint", int'(busy), 1);
    wait_cyc(c + 60);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_tick", int'(tick), 0);
    chk("midrst_base", int'(base_tick), 0);
    r = cyc;
    wait_cyc(r + 9);
    chk("post_rst_base_early", int'(base_tick), 0);
    wait_cyc(r + 10);
    chk("post_rst_base", int'(base_tick), 1);
    chk("post_rst_busy", int'(busy), 0);

    repeat (5) @(negedge clk);
    chk("pending_expected", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
